universal_ff_bank: RTL and testbench

UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

---
 rtl/universal_ff_bank.sv | 106 ++++++++++
 tb/tb_universal_ff_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_ff_bank.sv
// Bank of WIDTH flip-flops that behave as D, T, JK or SR cells chosen by mode.
// Illegal SR combinations (S=R=1) hold the bit and set a sticky flag plus a saturating event counter.
module universal_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [1:0]       MODE_D  = 2'b00;
    localparam logic [1:0]       MODE_T  = 2'b01;
    localparam logic [1:0]       MODE_JK = 2'b10;
    localparam logic [1:0]       MODE_SR = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             illegal_reg;
    logic             illegal_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             illegal_cycle;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_next;

            always_comb begin
                bit_next = q_reg[gi];
                if (en) begin
                    case (mode)
                        MODE_D:  bit_next = a[gi];
                        MODE_T:  bit_next = q_reg[gi] ^ a[gi];
                        MODE_JK: begin
                            case ({a[gi], b[gi]})
                                2'b01:   bit_next = 1'b0;
                                2'b10:   bit_next = 1'b1;
                                2'b11:   bit_next = ~q_reg[gi];
                                default: bit_next = q_reg[gi];
                            endcase
                        end
                        default: begin
                            // SR: S=R=1 holds the bit so the state never goes unknown
                            case ({a[gi], b[gi]})
                                2'b01:   bit_next = 1'b0;
                                2'b10:   bit_next = 1'b1;
                                default: bit_next = q_reg[gi];
                            endcase
                        end
                    endcase
                end
            end

            assign q_next[gi] = bit_next;
        end
    endgenerate

    // Any number of offending bits in one cycle is a single event
    assign illegal_cycle = en && (mode == MODE_SR) && (|(a & b));

    always_comb begin
        illegal_next = illegal_reg;
        cnt_next     = cnt_reg;
        if (illegal_cycle) begin
            illegal_next = 1'b1;
            if (clr_err) begin
                cnt_next = CNT_W'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (clr_err) begin
            illegal_next = 1'b0;
            cnt_next     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= RST_VAL;
            illegal_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            q_reg       <= q_next;
            illegal_reg <= illegal_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign q           = q_reg;
    assign qbar        = ~q_reg;
    assign illegal     = illegal_reg;
    assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed plus randomized check of universal_ff_bank; expected values queue up at drive time
// and are popped after the following rising edge.
module tb_universal_ff_bank;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       ill;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       illegal;
    logic [3:0] illegal_cnt;

    exp_t sb[$];
    int   n_cmp;
    int   n_fail;

    // Bench-side reference state for the randomized phase
    logic [7:0] m_q;
    logic       m_ill;
    logic [3:0] m_cnt;

    universal_ff_bank #(
        .WIDTH   (8),
        .CNT_W   (4),
        .RST_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .a           (a),
        .b           (b),
        .clr_err     (clr_err),
        .q           (q),
        .qbar        (qbar),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert (q === e.q) else begin
                n_fail++;
                $error("FAIL %s q observed=%h expected=%h", e.tag, q, e.q);
            end
            n_cmp++;
            assert (qbar === ~e.q) else begin
                n_fail++;
                $error("FAIL %s qbar observed=%h expected=%h", e.tag, qbar, ~e.q);
            end
            n_cmp++;
            assert (illegal === e.ill) else begin
                n_fail++;
                $error("FAIL %s illegal observed=%b expected=%b", e.tag, illegal, e.ill);
            end
            n_cmp++;
            assert (illegal_cnt === e.cnt) else begin
                n_fail++;
                $error("FAIL %s illegal_cnt observed=%0d expected=%0d", e.tag, illegal_cnt, e.cnt);
            end
            $display("[%0t] %s: rst=%b en=%b mode=%b a=%h b=%h clr=%b -> q=%h ill=%b cnt=%0d",
                     $time, e.tag, rst, en, mode, a, b, clr_err, q, illegal, illegal_cnt);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] aa, input logic [7:0] bb, input logic ce,
                        input logic [7:0] eq, input logic eill, input logic [3:0] ecnt,
                        input string tag);
        exp_t x;
        @(negedge clk);
        rst     = r;
        en      = e;
        mode    = m;
        a       = aa;
        b       = bb;
        clr_err = ce;
        x.tag = tag;
        x.q   = eq;
        x.ill = eill;
        x.cnt = ecnt;
        sb.push_back(x);
        m_q   = eq;
        m_ill = eill;
        m_cnt = ecnt;
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [7:0] ref_q(input logic [1:0] m, input logic [7:0] qq,
                                         input logic [7:0] aa, input logic [7:0] bb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00: r[i] = aa[i];
                2'b01: r[i] = qq[i] ^ aa[i];
                2'b10: r[i] = (aa[i] & bb[i]) ? ~qq[i] : (aa[i] ? 1'b1 : (bb[i] ? 1'b0 : qq[i]));
                default: r[i] = (aa[i] & ~bb[i]) ? 1'b1 : ((~aa[i] & bb[i]) ? 1'b0 : qq[i]);
            endcase
        end
        return r;
    endfunction

    initial begin
        logic       r_r;
        logic       r_e;
        logic [1:0] r_m;
        logic [7:0] r_a;
        logic [7:0] r_b;
        logic       r_c;
        logic [7:0] x_q;
        logic       x_ill;
        logic [3:0] x_cnt;
        logic       ev;

        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        mode    = 2'b00;
        a       = 8'h00;
        b       = 8'h00;
        clr_err = 1'b0;

        // Reset and D mode
        step(1, 0, 2'b00, 8'h00, 8'h00, 0, 8'h00, 0, 4'd0, "reset");
        step(0, 1, 2'b00, 8'hA5, 8'h00, 0, 8'hA5, 0, 4'd0, "d_load");
        step(0, 0, 2'b00, 8'h3C, 8'h00, 0, 8'hA5, 0, 4'd0, "en_low_hold");
        // T and JK
        step(0, 1, 2'b01, 8'h0F, 8'h00, 0, 8'hAA, 0, 4'd0, "t_toggle");
        step(0, 1, 2'b10, 8'hF0, 8'h0F, 0, 8'hF0, 0, 4'd0, "jk_set_clr");
        step(0, 1, 2'b10, 8'hFF, 8'hFF, 0, 8'h0F, 0, 4'd0, "jk_toggle");
        // SR with one illegal bit and one set bit
        step(0, 1, 2'b11, 8'h81, 8'h01, 0, 8'h8F, 1, 4'd1, "sr_illegal");
        // Saturation
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 2'b11, 8'h01, 8'h01, 0, 8'h8F, 1, (k + 1 > 15) ? 4'd15 : 4'(k + 1), "sr_saturate");
        end
        step(0, 1, 2'b11, 8'h00, 8'h00, 1, 8'h8F, 0, 4'd0, "clr_err");
        step(0, 1, 2'b11, 8'h10, 8'h02, 0, 8'h9D, 0, 4'd0, "sr_set_clr");
        // clr_err loses to a simultaneous illegal event
        step(0, 1, 2'b11, 8'h04, 8'h04, 0, 8'h9D, 1, 4'd1, "sr_illegal_a");
        step(0, 1, 2'b11, 8'hFF, 8'hFF, 0, 8'h9D, 1, 4'd2, "sr_illegal_multi");
        step(0, 1, 2'b11, 8'h04, 8'h04, 1, 8'h9D, 1, 4'd1, "clr_vs_illegal");
        // Reset wins over an illegal cycle
        step(1, 1, 2'b11, 8'hFF, 8'hFF, 1, 8'h00, 0, 4'd0, "rst_vs_illegal");
        step(0, 1, 2'b00, 8'h3C, 8'h00, 0, 8'h3C, 0, 4'd0, "first_after_rst");
        step(0, 0, 2'b11, 8'hFF, 8'hFF, 0, 8'h3C, 0, 4'd0, "en_low_no_event");
        step(0, 1, 2'b10, 8'h00, 8'h00, 0, 8'h3C, 0, 4'd0, "jk_hold");
        step(0, 1, 2'b01, 8'hFF, 8'h00, 0, 8'hC3, 0, 4'd0, "mode_switch_t");
        step(0, 1, 2'b11, 8'hC3, 8'h3C, 0, 8'hC3, 0, 4'd0, "sr_noop_values");

        // Randomized traffic against the reference
        for (int k = 0; k < 60; k++) begin
            r_r = ($urandom_range(0, 19) == 0);
            r_e = ($urandom_range(0, 3) != 0);
            r_m = 2'($urandom_range(0, 3));
            r_a = 8'($urandom);
            r_b = 8'($urandom);
            r_c = ($urandom_range(0, 5) == 0);
            ev  = r_e && (r_m == 2'b11) && ((r_a & r_b) != 8'h00);
            if (r_r) begin
                x_q = 8'h00; x_ill = 1'b0; x_cnt = 4'd0;
            end else begin
                x_q = r_e ? ref_q(r_m, m_q, r_a, r_b) : m_q;
                if (ev) begin
                    x_ill = 1'b1;
                    x_cnt = r_c ? 4'd1 : ((m_cnt == 4'd15) ? 4'd15 : m_cnt + 4'd1);
                end else if (r_c) begin
                    x_ill = 1'b0; x_cnt = 4'd0;
                end else begin
                    x_ill = m_ill; x_cnt = m_cnt;
                end
            end
            step(r_r, r_e, r_m, r_a, r_b, r_c, x_q, x_ill, x_cnt, "random");
        end

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
